// File: rtl/spi_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : spi_mem_ctrl
// Brief    : SPI word decoder / sequencer driving a req-gnt single-port memory.
//            Optional address auto-increment: SPI_MEM_CTRL_AUTOINC_EN
// Revision : 1.0
// ============================================================================
module spi_mem_ctrl #(
    parameter int ADDR_WIDTH  = 8,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [9:0]            rx_data,
    input  logic                  rx_valid,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [7:0]            mem_rdata,
    output logic                  busy,
    output logic                  err_seq,
    output logic                  err_drop,
    output logic                  err_timeout
);

    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        RD_REQ  = 3'd2,
        RD_WAIT = 3'd3,
        TX      = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  rd_addr_vld_q, rd_addr_vld_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic                  tx_valid_q, tx_valid_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]            mem_wdata_q, mem_wdata_d;
    logic                  busy_q, busy_d;
    logic                  err_seq_q, err_seq_d;
    logic                  err_drop_q, err_drop_d;
    logic                  err_timeout_q, err_timeout_d;
    logic                  timeout_hit;

    always_comb begin
        state_d       = state_q;
        wr_addr_d     = wr_addr_q;
        rd_addr_d     = rd_addr_q;
        rd_addr_vld_d = rd_addr_vld_q;
        cnt_d         = cnt_q + 1'b1;
        tx_data_d     = tx_data_q;
        tx_valid_d    = 1'b0;
        mem_wdata_d   = mem_wdata_q;
        err_seq_d     = 1'b0;
        err_drop_d    = 1'b0;
        err_timeout_d = 1'b0;
        timeout_hit   = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

        case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    case (rx_data[9:8])
                        2'b00: wr_addr_d = rx_data[ADDR_WIDTH-1:0];
                        2'b01: begin
                            mem_wdata_d = rx_data[7:0];
                            state_d     = WR_REQ;
                        end
                        2'b10: begin
                            rd_addr_d     = rx_data[ADDR_WIDTH-1:0];
                            rd_addr_vld_d = 1'b1;
                        end
                        default: begin
                            if (rd_addr_vld_q) state_d = RD_REQ;
                            else               err_seq_d = 1'b1;
                        end
                    endcase
                end
            end
            WR_REQ: begin
                if (mem_gnt) begin
                    state_d = IDLE;
`ifdef SPI_MEM_CTRL_AUTOINC_EN
                    wr_addr_d = wr_addr_q + 1'b1;
`endif
                end else if (timeout_hit) begin
                    state_d       = IDLE;
                    err_timeout_d = 1'b1;
                end
            end
            RD_REQ, RD_WAIT: begin
                // Read data may arrive in the same cycle as the grant.
                if (mem_rvalid && (mem_gnt || state_q == RD_WAIT)) begin
                    state_d    = TX;
                    tx_data_d  = mem_rdata;
                    tx_valid_d = 1'b1;
                end else if (mem_gnt && state_q == RD_REQ) begin
                    state_d = RD_WAIT;
                end else if (timeout_hit) begin
                    state_d       = IDLE;
                    err_timeout_d = 1'b1;
                    tx_data_d     = 8'hFF;
                    tx_valid_d    = 1'b1;
                    rd_addr_vld_d = 1'b0;
                end
            end
            TX: begin
                state_d = IDLE;
`ifdef SPI_MEM_CTRL_AUTOINC_EN
                rd_addr_d = rd_addr_q + 1'b1;
`else
                rd_addr_vld_d = 1'b0;
`endif
            end
            default: state_d = IDLE;
        endcase

        if (rx_valid && state_q != IDLE) err_drop_d = 1'b1;
        if (state_d != state_q)          cnt_d = '0;

        // Registered outputs follow the state being entered.
        mem_req_d  = (state_d == WR_REQ) || (state_d == RD_REQ);
        mem_we_d   = (state_d == WR_REQ);
        mem_addr_d = mem_addr_q;
        if (state_d == WR_REQ)      mem_addr_d = wr_addr_q;
        else if (state_d == RD_REQ) mem_addr_d = rd_addr_q;
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            wr_addr_q     <= '0;
            rd_addr_q     <= '0;
            rd_addr_vld_q <= 1'b0;
            cnt_q         <= '0;
            tx_data_q     <= 8'h00;
            tx_valid_q    <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= 8'h00;
            busy_q        <= 1'b0;
            err_seq_q     <= 1'b0;
            err_drop_q    <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_addr_q     <= wr_addr_d;
            rd_addr_q     <= rd_addr_d;
            rd_addr_vld_q <= rd_addr_vld_d;
            cnt_q         <= cnt_d;
            tx_data_q     <= tx_data_d;
            tx_valid_q    <= tx_valid_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            busy_q        <= busy_d;
            err_seq_q     <= err_seq_d;
            err_drop_q    <= err_drop_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign tx_data     = tx_data_q;
    assign tx_valid    = tx_valid_q;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign busy        = busy_q;
    assign err_seq     = err_seq_q;
    assign err_drop    = err_drop_q;
    assign err_timeout = err_timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_mem_ctrl
// Brief    : Scoreboard bench for spi_mem_ctrl with a randomized memory responder.
// Revision : 1.0
// ============================================================================
module tb_spi_mem_ctrl;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       mem_req, mem_we;
    logic [7:0] mem_addr, mem_wdata;
    logic       mem_gnt, mem_rvalid;
    logic [7:0] mem_rdata;
    logic       busy, err_seq, err_drop, err_timeout;

    always #5 clk = ~clk;

    spi_mem_ctrl #(.ADDR_WIDTH(8), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .busy(busy),
        .err_seq(err_seq), .err_drop(err_drop), .err_timeout(err_timeout)
    );

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    typedef struct packed {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
    } acc_t;

    acc_t       exp_mem[$];
    logic [7:0] exp_tx[$];
    int         exp_seq = 0, exp_drop = 0, exp_to = 0;

    // Reference model state
    logic [7:0] ref_mem[256];
    logic [7:0] m_wa, m_ra;
    bit         m_vld;

    // Responder controls and storage
    logic [7:0] resp_mem[256];
    bit         stall_gnt = 0, stall_rv = 0, fast = 0, inject_rv = 0;

    function automatic int outs();
        return int'({tx_data, tx_valid, mem_req, mem_we, mem_addr, mem_wdata,
                     busy, err_seq, err_drop, err_timeout});
    endfunction

    task automatic reset_model();
        m_wa = 8'h00; m_ra = 8'h00; m_vld = 0;
    endtask

    task automatic model(input logic [9:0] w);
        logic [1:0] c;
        logic [7:0] p;
        c = w[9:8];
        p = w[7:0];
        case (c)
            2'd0: m_wa = p;
            2'd1: begin
                if (stall_gnt) exp_to++;
                else begin
                    exp_mem.push_back('{1'b1, m_wa, p});
                    ref_mem[m_wa] = p;
`ifdef SPI_MEM_CTRL_AUTOINC_EN
                    m_wa = m_wa + 8'd1;
`endif
                end
            end
            2'd2: begin m_ra = p; m_vld = 1; end
            default: begin
                if (!m_vld) exp_seq++;
                else if (stall_gnt || stall_rv) begin
                    if (stall_rv) exp_mem.push_back('{1'b0, m_ra, 8'h00});
                    exp_to++;
                    exp_tx.push_back(8'hFF);
                    m_vld = 0;
                end else begin
                    exp_mem.push_back('{1'b0, m_ra, 8'h00});
                    exp_tx.push_back(ref_mem[m_ra]);
`ifdef SPI_MEM_CTRL_AUTOINC_EN
                    m_ra = m_ra + 8'd1;
`else
                    m_vld = 0;
`endif
                end
            end
        endcase
    endtask

    task automatic drive(input logic [9:0] w);
        rx_data  = w;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        rx_data  = 10'($urandom);
    endtask

    task automatic issue(input logic [9:0] w);
        model(w);
        drive(w);
    endtask

    task automatic drop(input logic [9:0] w);
        exp_drop++;
        drive(w);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("busy_cleared", int'(busy), 0);
    endtask

    // Memory responder: bounded random grant and read-data delays.
    initial begin
        int         gdly = 0, rv_cnt = 0, rd = 0;
        bit         req_active = 0;
        logic [7:0] rv_addr = 8'h00;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 8'h00;
        forever begin
            @(posedge clk); #1;
            mem_gnt    = 0;
            mem_rvalid = 0;
            mem_rdata  = 8'($urandom);
            if (!rst_n) begin
                req_active = 0; rv_cnt = 0;
                continue;
            end
            if (inject_rv) begin
                mem_rvalid = 1;
                continue;
            end
            if (rv_cnt > 0) begin
                rv_cnt--;
                if (rv_cnt == 0) begin
                    mem_rvalid = 1;
                    mem_rdata  = resp_mem[rv_addr];
                end
            end
            if (mem_req) begin
                if (!req_active) begin
                    req_active = 1;
                    gdly = fast ? 0 : int'($urandom_range(0, 3));
                end
                if (!stall_gnt) begin
                    if (gdly > 0) gdly--;
                    else begin
                        mem_gnt    = 1;
                        req_active = 0;
                        if (mem_we) resp_mem[mem_addr] = mem_wdata;
                        else if (!stall_rv) begin
                            rd = fast ? 1 : int'($urandom_range(0, 3));
                            if (rd == 0) begin
                                mem_rvalid = 1;
                                mem_rdata  = resp_mem[mem_addr];
                            end else begin
                                rv_cnt  = rd;
                                rv_addr = mem_addr;
                            end
                        end
                    end
                end
            end else req_active = 0;
        end
    end

    // Monitor: pops expectations whenever the DUT presents an event.
    initial begin
        acc_t a;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (mem_req && mem_gnt) begin
                    chk("mem_access_expected", int'(exp_mem.size() > 0), 1);
                    if (exp_mem.size() > 0) begin
                        a = exp_mem.pop_front();
                        chk("mem_we", int'(mem_we), int'(a.we));
                        chk("mem_addr", int'(mem_addr), int'(a.addr));
                        if (a.we) chk("mem_wdata", int'(mem_wdata), int'(a.wdata));
                    end
                end
                if (tx_valid) begin
                    chk("tx_expected", int'(exp_tx.size() > 0), 1);
                    if (exp_tx.size() > 0) chk("tx_data", int'(tx_data), int'(exp_tx.pop_front()));
                end
                if (err_seq) begin
                    chk("err_seq_expected", int'(exp_seq > 0), 1);
                    if (exp_seq > 0) exp_seq--;
                end
                if (err_drop) begin
                    chk("err_drop_expected", int'(exp_drop > 0), 1);
                    if (exp_drop > 0) exp_drop--;
                end
                if (err_timeout) begin
                    chk("err_timeout_expected", int'(exp_to > 0), 1);
                    if (exp_to > 0) exp_to--;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0]  v;
        logic [1:0]  c;
        logic [9:0]  w;
        int          n, g, lat, r;
        bit          started;
        for (int i = 0; i < 256; i++) begin
            v = 8'($urandom);
            ref_mem[i]  = v;
            resp_mem[i] = v;
        end
        reset_model();
        rx_valid = 0;
        rx_data  = 10'h000;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", outs(), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Read-data with no read address
        issue(10'h300);
        repeat (3) begin
            chk("no_req_after_seq_err", int'(mem_req | tx_valid), 0);
            @(posedge clk); #1;
        end

        // Write then read-back with immediate grant
        fast = 1;
        issue(10'h012);
        issue(10'h1A5);
        wait_idle();
        issue(10'h212);
        issue(10'h300);
        lat = 1;
        while (!tx_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("read_latency", lat, 3);
        wait_idle();
        fast = 0;
        issue(10'h300);
        wait_idle();

        // Read timeout waiting for grant
        stall_gnt = 1;
        issue(10'h233);
        issue(10'h300);
        n = 0; g = 0;
        while (!err_timeout && g < 100) begin
            if (mem_req) n++;
            @(posedge clk); #1;
            g++;
        end
        chk("timeout_req_cycles", n, TO);
        chk("timeout_idle", int'({mem_req, busy, tx_data}), 8'hFF);
        wait_idle();
        issue(10'h140);
        wait_idle();
        stall_gnt = 0;
        // Read timeout waiting for data
        stall_rv = 1;
        issue(10'h244);
        issue(10'h300);
        wait_idle();
        stall_rv = 0;
        issue(10'h300);
        wait_idle();

        // Randomized traffic
        for (int i = 0; i < 250; i++) begin
            r = int'($urandom_range(0, 99));
            c = 2'($urandom);
            v = (r < 50) ? 8'($urandom_range(0, 15)) : 8'($urandom);
            w = {c, v};
            if (r < 4) stall_gnt = 1;
            else if (r < 8 && c == 2'd3) stall_rv = 1;
            started = (c == 2'd1) || (c == 2'd3 && m_vld);
            issue(w);
            if (started && $urandom_range(0, 3) == 0) drop(10'($urandom));
            wait_idle();
            stall_gnt = 0;
            stall_rv  = 0;
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
            end
        end

        // Drop during RD_WAIT, then asynchronous reset mid-read
        stall_rv = 1;
        issue(10'h2AA);
        exp_mem.push_back('{1'b0, 8'hAA, 8'h00});
        drive(10'h300);
        drop(10'h055);
        repeat (6) @(posedge clk);
        #1;
        chk("busy_in_rd_wait", int'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", outs(), 0);
        reset_model();
        stall_rv = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        inject_rv = 1;
        @(negedge clk);
        inject_rv = 0;
        repeat (3) begin
            @(negedge clk);
            chk("late_rvalid_ignored", int'({tx_valid, busy}), 0);
        end
        @(posedge clk); #1;

        // Sequential address streaming
        issue(10'h0FF);
        issue(10'h111);
        wait_idle();
        issue(10'h122);
        wait_idle();
        issue(10'h2FE);
        for (int i = 0; i < 3; i++) begin
            issue(10'h300);
            wait_idle();
        end

        repeat (5) @(posedge clk);
        chk("pending_mem", exp_mem.size(), 0);
        chk("pending_tx", exp_tx.size(), 0);
        chk("pending_err", exp_seq + exp_drop + exp_to, 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
